cpu_mem_responder: RTL and testbench

Memory responder serving the CPU control FSM's instruction-fetch and data-access strobes. Holds a 32 x 8-bit unified program/data store. Answers each strobe after a programmable number of wait states with a one-cycle `ready` pulse and registered read data. A backdoor load port preloads programs. The block sits between the control/datapath and storage, replacing the ideal zero-latency memory.

---
 rtl/cpu_mem_responder.sv | 139 +++++++++++++
 tb/tb_cpu_mem_responder.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_mem_responder.sv
// Unified 32x8 program/data store answering CPU fetch/read/write strobes
// after WAIT_CYCLES wait states, with a backdoor preload port.
module cpu_mem_responder #(
  parameter int unsigned AW          = 5,
  parameter int unsigned DW          = 8,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          memIns_en,
  input  logic [AW-1:0] ins_addr,
  input  logic          memDa_en,
  input  logic          memDa_we,
  input  logic [AW-1:0] da_addr,
  input  logic [DW-1:0] wr_data,
  input  logic          load_we,
  input  logic [AW-1:0] load_addr,
  input  logic [DW-1:0] load_data,
  output logic [DW-1:0] ins_data,
  output logic [DW-1:0] da_data,
  output logic          ready,
  output logic          busy,
  output logic          overrun
);

  localparam int unsigned CW    = 4;
  localparam int unsigned DEPTH = 1 << AW;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;
  typedef enum logic [1:0] {K_FETCH, K_WRITE, K_READ} kind_t;

  state_t        r_state;
  state_t        w_state_nx;
  kind_t         r_kind;
  kind_t         w_req_kind;
  kind_t         w_kind_cur;
  logic [AW-1:0] r_addr;
  logic [AW-1:0] w_req_addr;
  logic [AW-1:0] w_addr_cur;
  logic [DW-1:0] r_wdata;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_mem [DEPTH];

  logic          r_ready;
  logic          r_busy;
  logic          r_overrun;
  logic [DW-1:0] r_ins_data;
  logic [DW-1:0] r_da_data;

  logic w_fetch;
  logic w_write;
  logic w_read;
  logic w_any;
  logic w_ovr_set;
  logic w_commit;
  logic w_enter_done;

  assign w_fetch = memIns_en;
  assign w_write = memDa_we;
  assign w_read  = memDa_en & ~memDa_we;
  assign w_any   = w_fetch | w_write | w_read;

  // State register
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nx;
  end

  // Next-state logic
  always_comb begin
    w_state_nx = r_state;
    case (r_state)
      S_IDLE:  if (w_any) w_state_nx = (WAIT_CYCLES > 0) ? S_WAIT : S_DONE;
      S_WAIT:  if (r_cnt == CW'(1)) w_state_nx = S_DONE;
      S_DONE:  w_state_nx = S_IDLE;
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Output/control decode; IDLE uses the incoming winner so zero-wait accesses work
  always_comb begin
    w_req_kind = K_READ;
    w_req_addr = da_addr;
    if (w_fetch) begin
      w_req_kind = K_FETCH;
      w_req_addr = ins_addr;
    end else if (w_write) begin
      w_req_kind = K_WRITE;
    end
    w_kind_cur   = (r_state == S_IDLE) ? w_req_kind : r_kind;
    w_addr_cur   = (r_state == S_IDLE) ? w_req_addr : r_addr;
    w_enter_done = (w_state_nx == S_DONE);
    w_ovr_set    = (r_state == S_IDLE) ? (w_fetch & (w_write | w_read))
                                       : (memIns_en | memDa_en | memDa_we);
    w_commit     = (r_state == S_DONE) && (r_kind == K_WRITE);
  end

  // Request latch, wait counter and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_kind     <= K_FETCH;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cnt      <= '0;
      r_ready    <= 1'b0;
      r_busy     <= 1'b0;
      r_overrun  <= 1'b0;
      r_ins_data <= '0;
      r_da_data  <= '0;
    end else begin
      r_ready <= w_enter_done;
      r_busy  <= (w_state_nx != S_IDLE);
      if (w_ovr_set) r_overrun <= 1'b1;
      if (r_state == S_IDLE && w_any) begin
        r_kind  <= w_req_kind;
        r_addr  <= w_req_addr;
        r_wdata <= wr_data;
        r_cnt   <= CW'(WAIT_CYCLES);
      end else if (r_state == S_WAIT) begin
        r_cnt <= r_cnt - CW'(1);
      end
      if (w_enter_done && w_kind_cur == K_FETCH) r_ins_data <= r_mem[w_addr_cur];
      if (w_enter_done && w_kind_cur == K_READ)  r_da_data  <= r_mem[w_addr_cur];
    end
  end

  // Storage: CPU write commits at the end of DONE; backdoor issued later so it wins
  always_ff @(posedge clk) begin
    if (!rst && w_commit) r_mem[r_addr] <= r_wdata;
    if (load_we)          r_mem[load_addr] <= load_data;
  end

  assign ready    = r_ready;
  assign busy     = r_busy;
  assign overrun  = r_overrun;
  assign ins_data = r_ins_data;
  assign da_data  = r_da_data;

endmodule

// File: tb/tb_cpu_mem_responder.sv
// Directed bench: three responders (0, 2 and 3 wait states) share one stimulus stream.
module tb_cpu_mem_responder;

  logic       clk = 1'b0;
  logic       rst;
  logic       memIns_en;
  logic [4:0] ins_addr;
  logic       memDa_en;
  logic       memDa_we;
  logic [4:0] da_addr;
  logic [7:0] wr_data;
  logic       load_we;
  logic [4:0] load_addr;
  logic [7:0] load_data;

  // index 0: WAIT_CYCLES=0, 1: WAIT_CYCLES=2, 2: WAIT_CYCLES=3
  logic [7:0] ins_data [3];
  logic [7:0] da_data  [3];
  logic       ready    [3];
  logic       busy     [3];
  logic       overrun  [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cpu_mem_responder #(.AW(5), .DW(8), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .rst(rst), .memIns_en(memIns_en), .ins_addr(ins_addr),
    .memDa_en(memDa_en), .memDa_we(memDa_we), .da_addr(da_addr), .wr_data(wr_data),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .ins_data(ins_data[0]), .da_data(da_data[0]), .ready(ready[0]),
    .busy(busy[0]), .overrun(overrun[0]));

  cpu_mem_responder #(.AW(5), .DW(8), .WAIT_CYCLES(2)) u_w2 (
    .clk(clk), .rst(rst), .memIns_en(memIns_en), .ins_addr(ins_addr),
    .memDa_en(memDa_en), .memDa_we(memDa_we), .da_addr(da_addr), .wr_data(wr_data),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .ins_data(ins_data[1]), .da_data(da_data[1]), .ready(ready[1]),
    .busy(busy[1]), .overrun(overrun[1]));

  cpu_mem_responder #(.AW(5), .DW(8), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .rst(rst), .memIns_en(memIns_en), .ins_addr(ins_addr),
    .memDa_en(memDa_en), .memDa_we(memDa_we), .da_addr(da_addr), .wr_data(wr_data),
    .load_we(load_we), .load_addr(load_addr), .load_data(load_data),
    .ins_data(ins_data[2]), .da_data(da_data[2]), .ready(ready[2]),
    .busy(busy[2]), .overrun(overrun[2]));

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic clr_strobes();
    memIns_en = 1'b0;
    memDa_en  = 1'b0;
    memDa_we  = 1'b0;
    load_we   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr_strobes();
    ins_addr = '0; da_addr = '0; wr_data = '0; load_addr = '0; load_data = '0;
    tick(); tick();
    load_we = 1'b1; load_addr = 5'd0; load_data = 8'hA5; tick();
    load_addr = 5'd3; load_data = 8'h1F; tick();
    load_addr = 5'd2; load_data = 8'h00; tick();
    load_addr = 5'd9; load_data = 8'h00; tick();
    load_addr = 5'd5; load_data = 8'h00; tick();
    load_we = 1'b0; tick();
    for (int i = 0; i < 3; i++) begin
      total++; if (ready[i] !== 1'b0) begin bad++; $display("FAIL reset_ready[%0d] got=%b want=0", i, ready[i]); end
      total++; if (busy[i] !== 1'b0) begin bad++; $display("FAIL reset_busy[%0d] got=%b want=0", i, busy[i]); end
      total++; if (overrun[i] !== 1'b0) begin bad++; $display("FAIL reset_overrun[%0d] got=%b want=0", i, overrun[i]); end
      total++; if (ins_data[i] !== 8'h00) begin bad++; $display("FAIL reset_ins[%0d] got=%h want=00", i, ins_data[i]); end
      total++; if (da_data[i] !== 8'h00) begin bad++; $display("FAIL reset_da[%0d] got=%h want=00", i, da_data[i]); end
    end
    rst = 1'b0; tick();
  endtask

  task automatic test_fetch();
    memIns_en = 1'b1; ins_addr = 5'd0; tick();
    memIns_en = 1'b0;
    total++; if (ready[0] !== 1'b1) begin bad++; $display("FAIL fetch_w0_ready got=%b want=1", ready[0]); end
    total++; if (ins_data[0] !== 8'hA5) begin bad++; $display("FAIL fetch_w0_ins got=%h want=a5", ins_data[0]); end
    total++; if (busy[0] !== 1'b1) begin bad++; $display("FAIL fetch_w0_busy got=%b want=1", busy[0]); end
    total++; if (busy[2] !== 1'b1) begin bad++; $display("FAIL fetch_w3_busy got=%b want=1", busy[2]); end
    total++; if (ready[2] !== 1'b0) begin bad++; $display("FAIL fetch_w3_early got=%b want=0", ready[2]); end
    tick();
    total++; if (ready[0] !== 1'b0) begin bad++; $display("FAIL fetch_w0_pulse got=%b want=0", ready[0]); end
    total++; if (busy[0] !== 1'b0) begin bad++; $display("FAIL fetch_w0_busy_end got=%b want=0", busy[0]); end
    for (int k = 3; k <= 6; k++) begin
      tick();
      total++; if (ready[2] !== (k == 4)) begin bad++; $display("FAIL fetch_w3_ready_t%0d got=%b want=%b", k, ready[2], (k == 4)); end
    end
    total++; if (ins_data[2] !== 8'hA5) begin bad++; $display("FAIL fetch_w3_ins got=%h want=a5", ins_data[2]); end
  endtask

  task automatic test_priority();
    total++; if (overrun[0] !== 1'b0) begin bad++; $display("FAIL prio_pre_overrun got=%b want=0", overrun[0]); end
    memIns_en = 1'b1; ins_addr = 5'd0; memDa_en = 1'b1; da_addr = 5'd3; tick();
    clr_strobes();
    total++; if (ready[0] !== 1'b1) begin bad++; $display("FAIL prio_ready got=%b want=1", ready[0]); end
    total++; if (ins_data[0] !== 8'hA5) begin bad++; $display("FAIL prio_ins got=%h want=a5", ins_data[0]); end
    total++; if (da_data[0] !== 8'h00) begin bad++; $display("FAIL prio_da got=%h want=00", da_data[0]); end
    total++; if (overrun[0] !== 1'b1) begin bad++; $display("FAIL prio_overrun got=%b want=1", overrun[0]); end
    repeat (5) tick();
    total++; if (da_data[0] !== 8'h00) begin bad++; $display("FAIL prio_da_hold got=%h want=00", da_data[0]); end
    total++; if (overrun[0] !== 1'b1) begin bad++; $display("FAIL prio_overrun_sticky got=%b want=1", overrun[0]); end
  endtask

  task automatic test_write_read();
    memDa_we = 1'b1; da_addr = 5'd5; wr_data = 8'h3C;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 1) clr_strobes();
      total++; if (ready[2] !== (k == 4)) begin bad++; $display("FAIL wr_w3_ready_t%0d got=%b want=%b", k, ready[2], (k == 4)); end
    end
    total++; if (da_data[2] !== 8'h00) begin bad++; $display("FAIL wr_w3_da_untouched got=%h want=00", da_data[2]); end
    memDa_en = 1'b1; da_addr = 5'd5; tick();
    clr_strobes();
    repeat (3) tick();
    total++; if (ready[2] !== 1'b1) begin bad++; $display("FAIL rd_w3_ready got=%b want=1", ready[2]); end
    total++; if (da_data[2] !== 8'h3C) begin bad++; $display("FAIL rd_w3_da got=%h want=3c", da_data[2]); end
    total++; if (ins_data[2] !== 8'hA5) begin bad++; $display("FAIL rd_w3_ins_hold got=%h want=a5", ins_data[2]); end
    repeat (2) tick();
  endtask

  task automatic test_drop();
    rst = 1'b1; tick();
    rst = 1'b0;
    total++; if (overrun[1] !== 1'b0) begin bad++; $display("FAIL drop_pre_overrun got=%b want=0", overrun[1]); end
    memIns_en = 1'b1; ins_addr = 5'd0; tick();
    ins_addr = 5'd3;
    total++; if (busy[1] !== 1'b1) begin bad++; $display("FAIL drop_busy got=%b want=1", busy[1]); end
    total++; if (overrun[1] !== 1'b0) begin bad++; $display("FAIL drop_overrun_t1 got=%b want=0", overrun[1]); end
    tick();
    clr_strobes();
    total++; if (overrun[1] !== 1'b1) begin bad++; $display("FAIL drop_overrun_t2 got=%b want=1", overrun[1]); end
    total++; if (ready[1] !== 1'b0) begin bad++; $display("FAIL drop_ready_t2 got=%b want=0", ready[1]); end
    tick();
    total++; if (ready[1] !== 1'b1) begin bad++; $display("FAIL drop_ready_t3 got=%b want=1", ready[1]); end
    total++; if (ins_data[1] !== 8'hA5) begin bad++; $display("FAIL drop_ins got=%h want=a5", ins_data[1]); end
    tick();
    total++; if (ready[1] !== 1'b0) begin bad++; $display("FAIL drop_ready_t4 got=%b want=0", ready[1]); end
    repeat (3) tick();
    total++; if (ready[1] !== 1'b0) begin bad++; $display("FAIL drop_no_second got=%b want=0", ready[1]); end
    rst = 1'b1; tick();
    total++; if (overrun[1] !== 1'b0) begin bad++; $display("FAIL drop_rst_overrun got=%b want=0", overrun[1]); end
    total++; if (ins_data[1] !== 8'h00) begin bad++; $display("FAIL drop_rst_ins got=%h want=00", ins_data[1]); end
    total++; if (busy[1] !== 1'b0) begin bad++; $display("FAIL drop_rst_busy got=%b want=0", busy[1]); end
    rst = 1'b0;
    memIns_en = 1'b1; ins_addr = 5'd0; tick();
    clr_strobes();
    repeat (2) tick();
    total++; if (ready[1] !== 1'b1) begin bad++; $display("FAIL drop_refetch_ready got=%b want=1", ready[1]); end
    total++; if (ins_data[1] !== 8'hA5) begin bad++; $display("FAIL drop_mem_kept got=%h want=a5", ins_data[1]); end
    repeat (3) tick();
  endtask

  task automatic test_backdoor();
    memDa_we = 1'b1; da_addr = 5'd9; wr_data = 8'h11; tick();
    clr_strobes();
    load_we = 1'b1; load_addr = 5'd9; load_data = 8'h77; tick();
    load_we = 1'b0;
    repeat (5) tick();
    memDa_en = 1'b1; da_addr = 5'd9; tick();
    clr_strobes();
    repeat (4) tick();
    total++; if (da_data[0] !== 8'h77) begin bad++; $display("FAIL bd_w0_wins got=%h want=77", da_data[0]); end
    total++; if (da_data[1] !== 8'h11) begin bad++; $display("FAIL bd_w2_later_cpu got=%h want=11", da_data[1]); end
    total++; if (da_data[2] !== 8'h11) begin bad++; $display("FAIL bd_w3_later_cpu got=%h want=11", da_data[2]); end
  endtask

  task automatic test_reset_abort();
    memDa_we = 1'b1; da_addr = 5'd2; wr_data = 8'hFF; tick();
    clr_strobes(); tick();
    rst = 1'b1; tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      total++; if (ready[2] !== 1'b0) begin bad++; $display("FAIL abort_ready_%0d got=%b want=0", k, ready[2]); end
      tick();
    end
    memDa_en = 1'b1; da_addr = 5'd2; tick();
    clr_strobes();
    repeat (4) tick();
    total++; if (da_data[2] !== 8'h00) begin bad++; $display("FAIL abort_w3_mem got=%h want=00", da_data[2]); end
    total++; if (da_data[1] !== 8'h00) begin bad++; $display("FAIL abort_w2_mem got=%h want=00", da_data[1]); end
    total++; if (da_data[0] !== 8'hFF) begin bad++; $display("FAIL abort_w0_done_before got=%h want=ff", da_data[0]); end
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_write_read();
    test_drop();
    test_backdoor();
    test_reset_abort();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1);
  end

endmodule
